mod_key_ctrl: RTL

Front-panel controller for the modulator board. Takes two raw push-buttons (mode, run), debounces them with a shared sample tick, and turns presses into a modulation-mode selection (2FSK / 2PSK / 2DPSK / QPSK) plus a run enable. Any mode change is delivered to the modulator datapath through a valid/ack handshake. Sits between the board pins and the modulator top level.

---
 rtl/mod_pkg.sv | 19 +
 rtl/mod_key_ctrl_key_filter.sv | 41 ++++
 rtl/mod_key_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mod_pkg.sv
// Shared types for the modulator front-panel controller: modulation mode
// encoding and the key-controller FSM states.
`timescale 1ns/1ps
package mod_pkg;

    typedef enum logic [1:0] {
        MODE_2FSK  = 2'd0,
        MODE_2PSK  = 2'd1,
        MODE_2DPSK = 2'd2,
        MODE_QPSK  = 2'd3
    } mod_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } mod_state_t;

endpackage

// File: rtl/mod_key_ctrl_key_filter.sv
// Per-key debounce: samples the raw active-low button on each shared tick and
// emits a one-cycle press pulse when the debounced level falls 1->0.
`timescale 1ns/1ps
module key_filter
    import mod_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic press
);

    logic sample_q;
    logic stable_q;
    logic press_q;

    // Two agreeing tick samples move the stable level; the press pulse is
    // registered on the same edge so it is high the cycle after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (tick) begin
                sample_q <= raw;
                if (raw == sample_q) begin
                    stable_q <= raw;
                    press_q  <= stable_q & ~raw;
                end
            end
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/mod_key_ctrl.sv
// Front-panel key controller: shared debounce prescaler, mode/run FSM and the
// valid/ack handshake towards the modulator. Optional long-press panic reset
// on the run key is built when MOD_KEY_LONG_PRESS_EN is defined.
//
// state  | meaning
// IDLE   | modulator stopped, keys active
// RUN    | modulator enabled, keys active
// SWITCH | new mode presented on cfg_valid, waiting for cfg_ack
`timescale 1ns/1ps
module mod_key_ctrl
    import mod_pkg::*;
#(
    parameter int TICK_DIV   = 120000,
    parameter int LONG_TICKS = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_in,
    input  logic       key_run_in,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       cfg_valid,
    input  logic       cfg_ack,
    output logic       busy
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] div_q;
    logic             tick;

    assign tick = (div_q == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + CNT_W'(1);
        end
    end

    logic mode_stable, mode_press;
    logic run_stable, run_press;
    logic long_press;

    key_filter u_key_mode (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .raw    (key_mode_in),
        .stable (mode_stable),
        .press  (mode_press)
    );

    key_filter u_key_run (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .raw    (key_run_in),
        .stable (run_stable),
        .press  (run_press)
    );

`ifdef MOD_KEY_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              long_q;

    // Saturating hold count; the long pulse fires only on the step that
    // reaches LONG_TICKS, so a single hold triggers it once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (tick) begin
                if (run_stable) begin
                    hold_q <= '0;
                end else if (hold_q != HOLD_W'(LONG_TICKS)) begin
                    hold_q <= hold_q + HOLD_W'(1);
                    long_q <= (hold_q == HOLD_W'(LONG_TICKS - 1));
                end
            end
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

    logic unused_stable;
    assign unused_stable = mode_stable ^ run_stable;

    mod_state_t state_q, state_d;
    mod_mode_t  mode_q, mode_d;
    logic       resume_q, resume_d;
    logic       run_en_q, cfg_valid_q, busy_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        resume_d = resume_q;
        unique case (state_q)
            IDLE, RUN: begin
                if (long_press) begin
                    mode_d   = MODE_2FSK;
                    resume_d = 1'b0;
                    state_d  = SWITCH;
                end else if (mode_press) begin
                    mode_d   = mod_mode_t'(mode_q + 2'd1);
                    resume_d = (state_q == RUN);
                    state_d  = SWITCH;
                end else if (run_press) begin
                    state_d  = (state_q == RUN) ? IDLE : RUN;
                end
            end
            SWITCH: begin
                if (cfg_ack) begin
                    state_d = resume_q ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing combinational
    // reaches the pins from the keys or cfg_ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE_2FSK;
            resume_q    <= 1'b0;
            run_en_q    <= 1'b0;
            cfg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            resume_q    <= resume_d;
            run_en_q    <= (state_d == RUN);
            cfg_valid_q <= (state_d == SWITCH);
            busy_q      <= (state_d == SWITCH);
        end
    end

    assign mode      = mode_q;
    assign run_en    = run_en_q;
    assign cfg_valid = cfg_valid_q;
    assign busy      = busy_q;

endmodule
